// File: rtl/i2c_pkg.sv
// i2c_pkg: state encoding and R/W bit values shared by the I2C target and master FSMs.
package i2c_pkg;

   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK
   } i2c_tgt_state_e;

   localparam logic I2C_RW_WRITE = 1'b0;
   localparam logic I2C_RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync: two-flop synchronizers on scl/sda plus edge and START/STOP detection.
module i2c_bus_sync (
   input  logic clk,
   input  logic rst,
   input  logic scl,
   input  logic sda,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det,
   output logic sda_s
);

   logic [1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
   logic       scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
   logic       scl_s;

   always_comb begin
      scl_sync_d = {scl_sync_q[0], scl};
      sda_sync_d = {sda_sync_q[0], sda};
      scl_prev_d = scl_sync_q[1];
      sda_prev_d = sda_sync_q[1];
   end

   // Reset to the idle-bus level so release of reset never looks like an edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_sync_q <= 2'b11;
         sda_sync_q <= 2'b11;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_sync_q <= scl_sync_d;
         sda_sync_q <= sda_sync_d;
         scl_prev_q <= scl_prev_d;
         sda_prev_q <= sda_prev_d;
      end
   end

   assign scl_s     = scl_sync_q[1];
   assign sda_s     = sda_sync_q[1];
   assign scl_rise  = scl_s & ~scl_prev_q;
   assign scl_fall  = ~scl_s & scl_prev_q;
   assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
   assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_target_mem.sv
// i2c_target_mem: I2C target with a byte register file; pointer byte then data on
// writes, sequential data on reads, pointer wrapping at MEM_DEPTH.
module i2c_target_mem
   import i2c_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR  = 7'h50,
   parameter int         MEM_DEPTH = 16,
   localparam int        PTR_W     = $clog2(MEM_DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             scl,
   inout  wire              sda,
   output logic             busy,
   output logic             ack_err,
   output logic             wr_valid,
   output logic [PTR_W-1:0] wr_ptr,
   output logic [7:0]       wr_data
);

   logic scl_rise, scl_fall, start_det, stop_det, sda_s;

   i2c_bus_sync u_sync (
      .clk       (clk),
      .rst       (rst),
      .scl       (scl),
      .sda       (sda),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det),
      .sda_s     (sda_s)
   );

   i2c_tgt_state_e   state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [7:0]       sh_q, sh_d, wr_data_q, wr_data_d;
   logic [PTR_W-1:0] ptr_q, ptr_d, wr_ptr_q, wr_ptr_d;
   logic             sda_oe_q, sda_oe_d, busy_q, busy_d, rw_q, rw_d, mack_q, mack_d;
   logic             err_q, err_d, wr_valid_q, wr_valid_d;
   logic [7:0]       mem_q [MEM_DEPTH];
   logic [7:0]       byte_in, rd_byte;
   logic             in_byte, addr_rd;

   assign byte_in = {sh_q[6:0], sda_s};
   assign rd_byte = mem_q[ptr_q];
   assign in_byte = state_q inside {ADDR, PTR, WR_BYTE, RD_BYTE};
   assign addr_rd = state_q == ADDR_ACK && rw_q == I2C_RW_READ;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sh_d       = sh_q;
      ptr_d      = ptr_q;
      sda_oe_d   = sda_oe_q;
      busy_d     = busy_q;
      rw_d       = rw_q;
      mack_d     = mack_q;
      wr_valid_d = 1'b0;
      wr_ptr_d   = wr_ptr_q;
      wr_data_d  = wr_data_q;
      err_d      = sda_oe_q && scl_rise && sda_s;
      // The scl rise that frames a START/STOP is counted as a bit, hence >= 2
      if (start_det || stop_det) begin
         state_d  = stop_det ? IDLE : ADDR;
         busy_d   = busy_q && !stop_det;
         sda_oe_d = 1'b0;
         cnt_d    = '0;
         err_d    = err_d || (in_byte && cnt_q >= 4'd2);
      end else begin
         case (state_q)
            ADDR, PTR, WR_BYTE: if (scl_rise) begin
               sh_d  = byte_in;
               cnt_d = cnt_q == 4'd7 ? 4'd0 : cnt_q + 4'd1;
               if (cnt_q == 4'd7 && state_q == ADDR) begin
                  busy_d  = byte_in[7:1] == DEV_ADDR;
                  rw_d    = byte_in[0];
                  state_d = byte_in[7:1] == DEV_ADDR ? ADDR_ACK : IDLE;
               end else if (cnt_q == 4'd7 && state_q == PTR) begin
                  ptr_d   = byte_in[PTR_W-1:0];
                  state_d = PTR_ACK;
               end else if (cnt_q == 4'd7) begin
                  wr_valid_d = 1'b1;
                  wr_ptr_d   = ptr_q;
                  wr_data_d  = byte_in;
                  ptr_d      = ptr_q + PTR_W'(1);
                  state_d    = WR_ACK;
               end
            end
            // cnt 0: first fall starts the ACK; cnt 1: second fall ends it
            ADDR_ACK, PTR_ACK, WR_ACK: if (scl_fall) begin
               cnt_d    = cnt_q == 4'd0 ? 4'd1 : 4'd0;
               sda_oe_d = cnt_q == 4'd0;
               if (cnt_q != 4'd0) begin
                  state_d  = addr_rd ? RD_BYTE : (state_q == ADDR_ACK ? PTR : WR_BYTE);
                  sh_d     = addr_rd ? rd_byte : sh_q;
                  sda_oe_d = addr_rd && !rd_byte[7];
               end
            end
            RD_BYTE: begin
               if (scl_rise) begin
                  cnt_d   = cnt_q == 4'd7 ? 4'd0 : cnt_q + 4'd1;
                  ptr_d   = cnt_q == 4'd7 ? ptr_q + PTR_W'(1) : ptr_q;
                  state_d = cnt_q == 4'd7 ? RD_ACK : RD_BYTE;
               end
               if (scl_fall) begin
                  sh_d     = {sh_q[6:0], 1'b0};
                  sda_oe_d = !sh_q[6];
               end
            end
            RD_ACK: begin
               if (scl_rise) mack_d = !sda_s;
               if (scl_fall) begin
                  cnt_d    = cnt_q == 4'd0 ? 4'd1 : 4'd0;
                  sda_oe_d = 1'b0;
                  if (cnt_q != 4'd0) begin
                     state_d  = mack_q ? RD_BYTE : IDLE;
                     sh_d     = rd_byte;
                     sda_oe_d = mack_q && !rd_byte[7];
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         sh_q       <= '0;
         ptr_q      <= '0;
         sda_oe_q   <= 1'b0;
         busy_q     <= 1'b0;
         rw_q       <= I2C_RW_WRITE;
         mack_q     <= 1'b0;
         err_q      <= 1'b0;
         wr_valid_q <= 1'b0;
         wr_ptr_q   <= '0;
         wr_data_q  <= '0;
         for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sh_q       <= sh_d;
         ptr_q      <= ptr_d;
         sda_oe_q   <= sda_oe_d;
         busy_q     <= busy_d;
         rw_q       <= rw_d;
         mack_q     <= mack_d;
         err_q      <= err_d;
         wr_valid_q <= wr_valid_d;
         wr_ptr_q   <= wr_ptr_d;
         wr_data_q  <= wr_data_d;
         if (wr_valid_d) mem_q[ptr_q] <= byte_in;
      end
   end

   assign sda      = sda_oe_q ? 1'b0 : 1'bz;
   assign busy     = busy_q;
   assign ack_err  = err_q;
   assign wr_valid = wr_valid_q;
   assign wr_ptr   = wr_ptr_q;
   assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_i2c_target_mem.sv
// tb_i2c_target_mem: bit-banged I2C master with a memory model and write/read scoreboards.
module tb_i2c_target_mem;
   import i2c_pkg::*;

   localparam int Q = 5;

   logic       clk = 1'b0, rst = 1'b1, scl = 1'b1, m_low = 1'b0;
   wire        sda;
   logic       busy, ack_err, wr_valid;
   logic [3:0] wr_ptr;
   logic [7:0] wr_data;

   pullup (sda);
   assign sda = m_low ? 1'b0 : 1'bz;

   i2c_target_mem #(.DEV_ADDR(7'h50), .MEM_DEPTH(16)) dut (
      .clk      (clk),
      .rst      (rst),
      .scl      (scl),
      .sda      (sda),
      .busy     (busy),
      .ack_err  (ack_err),
      .wr_valid (wr_valid),
      .wr_ptr   (wr_ptr),
      .wr_data  (wr_data)
   );

   always #5 clk = ~clk;

   int          n_chk = 0, n_fail = 0, wr_cnt = 0, err_cnt = 0;
   logic [11:0] wr_q[$];
   logic [7:0]  rd_q[$];
   logic [7:0]  model [16];
   logic [3:0]  ptr_m = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && ack_err) err_cnt++;
      if (!rst && wr_valid) begin
         wr_cnt++;
         if (wr_q.size() == 0) check("wr_unexpected_q_size", wr_q.size(), 1);
         else begin
            logic [11:0] e;
            e = wr_q.pop_front();
            check("wr_ptr", wr_ptr, e[11:8]);
            check("wr_data", wr_data, e[7:0]);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic start_c();
      m_low = 1'b0; tick(Q);
      scl = 1'b1;   tick(2*Q);
      m_low = 1'b1; tick(2*Q);
      scl = 1'b0;   tick(Q);
   endtask

   task automatic stop_c();
      m_low = 1'b1; tick(Q);
      scl = 1'b1;   tick(2*Q);
      m_low = 1'b0; tick(2*Q);
   endtask

   task automatic send_bit(input logic b);
      m_low = ~b; tick(Q);
      scl = 1'b1; tick(2*Q);
      scl = 1'b0; tick(Q);
   endtask

   task automatic read_bit(output logic b);
      m_low = 1'b0; tick(Q);
      scl = 1'b1;   tick(Q);
      @(negedge clk) b = sda;
      tick(Q);
      scl = 1'b0;   tick(Q);
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack);
      for (int i = 7; i >= 0; i--) send_bit(d[i]);
      read_bit(ack);
   endtask

   task automatic read_byte(input logic nack, output logic [7:0] d);
      for (int i = 7; i >= 0; i--) read_bit(d[i]);
      send_bit(nack);
   endtask

   task automatic wr_acked(input string tag, input logic [7:0] d);
      logic a;
      write_byte(d, a);
      check(tag, a, 1'b0);
   endtask

   task automatic set_ptr(input logic [7:0] p);
      wr_acked("ptr_ack", p);
      ptr_m = p[3:0];
   endtask

   task automatic wr_data_byte(input logic [7:0] d);
      wr_q.push_back({ptr_m, d});
      model[ptr_m] = d;
      ptr_m++;
      wr_acked("data_ack", d);
   endtask

   task automatic rd_data_byte(input string tag, input logic nack);
      logic [7:0] got;
      rd_q.push_back(model[ptr_m]);
      ptr_m++;
      read_byte(nack, got);
      check(tag, got, rd_q.pop_front());
   endtask

   task automatic read_at(input string tag, input logic [7:0] p);
      start_c(); wr_acked("addr_w_ack", 8'hA0); set_ptr(p);
      start_c(); wr_acked("addr_r_ack", 8'hA1);
      rd_data_byte(tag, 1'b1);
      stop_c();
   endtask

   initial begin
      logic a;
      for (int i = 0; i < 16; i++) model[i] = '0;
      tick(3);
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_ack_err", ack_err, 0);
      check("rst_wr_valid", wr_valid, 0);
      check("rst_wr_ptr", wr_ptr, 0);
      check("rst_wr_data", wr_data, 0);
      check("rst_sda", sda, 1);
      rst = 1'b0;
      tick(4);

      // 1: simple write
      start_c();
      write_byte(8'hA0, a);
      check("t1_addr_ack", a, 0);
      check("t1_busy", busy, 1);
      set_ptr(8'h03);
      wr_data_byte(8'hA5);
      stop_c();
      tick(4);
      @(negedge clk);
      check("t1_busy_after_stop", busy, 0);
      check("t1_wr_cnt", wr_cnt, 1);

      // 2: pointer write, repeated START, read with NACK
      start_c(); wr_acked("t2_addr_w", 8'hA0); set_ptr(8'h03);
      start_c(); wr_acked("t2_addr_r", 8'hA1);
      rd_data_byte("t2_rd", 1'b1);
      check("t2_ptr", 32'(dut.ptr_q), 4);
      stop_c();

      // 3: wrong address is NACKed and ignored
      start_c();
      write_byte(8'hA2, a);
      check("t3_nack", a, 1);
      check("t3_busy", busy, 0);
      write_byte(8'h77, a);
      check("t3_nack_data", a, 1);
      stop_c();
      check("t3_wr_cnt", wr_cnt, 1);
      read_at("t3_mem3", 8'h03);

      // 4: write across the wrap point, then read it back sequentially
      start_c(); wr_acked("t4_addr", 8'hA0); set_ptr(8'h0F);
      wr_data_byte(8'h11);
      wr_data_byte(8'h22);
      stop_c();
      check("t4_wr_cnt", wr_cnt, 3);
      start_c(); wr_acked("t4_addr_w", 8'hA0); set_ptr(8'h0F);
      start_c(); wr_acked("t4_addr_r", 8'hA1);
      rd_data_byte("t4_rd15", 1'b0);
      rd_data_byte("t4_rd0", 1'b1);
      stop_c();
      check("t4_err_cnt", err_cnt, 0);

      // 5: STOP after 4 data bits
      start_c(); wr_acked("t5_addr", 8'hA0); set_ptr(8'h05);
      for (int i = 0; i < 4; i++) send_bit(i[0]);
      stop_c();
      tick(4);
      @(negedge clk);
      check("t5_err_cnt", err_cnt, 1);
      check("t5_wr_cnt", wr_cnt, 3);
      check("t5_state", 32'(dut.state_q), 32'(IDLE));
      check("t5_busy", busy, 0);
      read_at("t5_mem5", 8'h05);

      // 6: reset while the target holds the address ACK
      start_c();
      for (int i = 7; i >= 0; i--) send_bit(i == 5 || i == 7);
      m_low = 1'b0; tick(Q);
      scl = 1'b1;   tick(Q);
      @(negedge clk);
      check("t6_ack_low", sda, 0);
      rst = 1'b1;
      #1;
      check("t6_sda_rel", sda, 1);
      check("t6_busy", busy, 0);
      check("t6_ack_err", ack_err, 0);
      check("t6_wr_valid", wr_valid, 0);
      check("t6_wr_ptr", wr_ptr, 0);
      check("t6_wr_data", wr_data, 0);
      tick(2);
      rst = 1'b0;
      for (int i = 0; i < 16; i++) model[i] = '0;
      ptr_m = '0;
      tick(4);
      read_at("t6_mem15_cleared", 8'h0F);

      tick(4);
      check("end_err_cnt", err_cnt, 1);
      check("end_wr_q_empty", wr_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
